// File: rtl/n64_cfg_bridge_pkg.sv
// n64_cfg_bridge shared types: FSM states, MCU register
// indices and CTRL/STATUS bit positions.
package n64_cfg_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_CPU,
      DONE
   } e_state;

   typedef enum logic [2:0] {
      REG_CTRL    = 3'd0,
      REG_CMD     = 3'd1,
      REG_ARG0    = 3'd2,
      REG_ARG1    = 3'd3,
      REG_RESULT0 = 3'd4,
      REG_RESULT1 = 3'd5
   } e_cpu_reg;

   localparam int CTRL_DONE    = 0;
   localparam int CTRL_ERROR   = 1;
   localparam int CTRL_N64_IRQ = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_ERROR   = 1;
   localparam int STAT_TIMEOUT = 2;

endpackage

// File: rtl/n64_cfg_bridge_if.sv
// n64_cfg_bridge bus bundle: N64 config channel plus
// MCU register window. master = N64/MCU side, slave = bridge.
interface n64_cfg_bridge_if;

   logic        cfg_pending;
   logic [7:0]  cfg_cmd;
   logic [31:0] cfg_rdata_0;
   logic [31:0] cfg_rdata_1;
   logic        cfg_done;
   logic        cfg_error;
   logic [31:0] cfg_wdata_0;
   logic [31:0] cfg_wdata_1;
   logic        cfg_irq;
   logic [2:0]  cpu_address;
   logic        cpu_write;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_irq;

   modport master (
      output cfg_pending, cfg_cmd, cfg_rdata_0, cfg_rdata_1,
      output cpu_address, cpu_write, cpu_wdata,
      input  cfg_done, cfg_error, cfg_wdata_0, cfg_wdata_1,
      input  cfg_irq, cpu_rdata, cpu_irq
   );

   modport slave (
      input  cfg_pending, cfg_cmd, cfg_rdata_0, cfg_rdata_1,
      input  cpu_address, cpu_write, cpu_wdata,
      output cfg_done, cfg_error, cfg_wdata_0, cfg_wdata_1,
      output cfg_irq, cpu_rdata, cpu_irq
   );

endinterface

// File: rtl/n64_cfg_bridge_timeout.sv
// n64_cfg_bridge WAIT_CPU watchdog counter; expired is
// raised while enabled once TIMEOUT_CYCLES-1 is reached.
module n64_cfg_bridge_timeout #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [31:0] cnt_q;

   assign expired = en && (cnt_q == TIMEOUT_CYCLES - 32'd1);

   // count enabled cycles, saturating at the expiry value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/n64_cfg_bridge.sv
// n64_cfg_bridge: N64 config command -> MCU register window.
// Optional watchdog enabled by defining CFG_BRIDGE_TIMEOUT_EN.
module n64_cfg_bridge
   import n64_cfg_bridge_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input logic             clk,
   input logic             reset_n,
   n64_cfg_bridge_if.slave bus
);

   e_state      state_q;
   e_state      state_d;
   logic        done_q;
   logic        done_d;
   logic        err_q;
   logic        err_d;
   logic        tflag_q;
   logic        tflag_d;
   logic        irq_q;
   logic        accept;
   logic        expired;
   logic        ctrl_wr;
   logic [7:0]  cmd_q;
   logic [31:0] arg0_q;
   logic [31:0] arg1_q;
   logic [31:0] res0_q;
   logic [31:0] res1_q;
   logic [31:0] rdata;

   if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

`ifdef CFG_BRIDGE_TIMEOUT_EN
   n64_cfg_bridge_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (accept),
      .en     (state_q == WAIT_CPU),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif

   assign ctrl_wr = bus.cpu_write &&
                    (bus.cpu_address == REG_CTRL);

   // next state, completion and error/timeout status
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = err_q;
      tflag_d = tflag_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cfg_pending) begin
               accept  = 1'b1;
               err_d   = 1'b0;
               tflag_d = 1'b0;
               state_d = WAIT_CPU;
            end
         end
         WAIT_CPU: begin
            if (ctrl_wr && bus.cpu_wdata[CTRL_DONE]) begin
               err_d   = bus.cpu_wdata[CTRL_ERROR];
               done_d  = 1'b1;
               state_d = DONE;
            end else if (expired) begin
               err_d   = 1'b1;
               tflag_d = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and N64-facing status registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         tflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         tflag_q <= tflag_d;
      end
   end

   // N64 interrupt request, one pulse per CTRL write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= ctrl_wr && bus.cpu_wdata[CTRL_N64_IRQ];
      end
   end

   // capture command and arguments on accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_q  <= '0;
         arg0_q <= '0;
         arg1_q <= '0;
      end else if (accept) begin
         cmd_q  <= bus.cfg_cmd;
         arg0_q <= bus.cfg_rdata_0;
         arg1_q <= bus.cfg_rdata_1;
      end
   end

   // result words, MCU-writable in any state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res0_q <= '0;
         res1_q <= '0;
      end else if (bus.cpu_write) begin
         if (bus.cpu_address == REG_RESULT0) begin
            res0_q <= bus.cpu_wdata;
         end
         if (bus.cpu_address == REG_RESULT1) begin
            res1_q <= bus.cpu_wdata;
         end
      end
   end

   // MCU read mux
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         bus.cpu_address == REG_CTRL: begin
            rdata[STAT_BUSY]    = (state_q == WAIT_CPU);
            rdata[STAT_ERROR]   = err_q;
            rdata[STAT_TIMEOUT] = tflag_q;
         end
         bus.cpu_address == REG_CMD:     rdata = {24'd0, cmd_q};
         bus.cpu_address == REG_ARG0:    rdata = arg0_q;
         bus.cpu_address == REG_ARG1:    rdata = arg1_q;
         bus.cpu_address == REG_RESULT0: rdata = res0_q;
         bus.cpu_address == REG_RESULT1: rdata = res1_q;
         default:                        rdata = '0;
      endcase
   end

   assign bus.cpu_rdata   = rdata;
   assign bus.cpu_irq     = (state_q == WAIT_CPU);
   assign bus.cfg_done    = done_q;
   assign bus.cfg_error   = err_q;
   assign bus.cfg_irq     = irq_q;
   assign bus.cfg_wdata_0 = res0_q;
   assign bus.cfg_wdata_1 = res1_q;

endmodule

// File: tb/tb_n64_cfg_bridge.sv
// n64_cfg_bridge bench: scoreboard of expected completions,
// IRQ pulses and register probes against a transaction model.
module tb_n64_cfg_bridge;
   import n64_cfg_bridge_pkg::*;

   localparam int SEL_RDATA = 0;
   localparam int SEL_CIRQ  = 1;
   localparam int SEL_DONE  = 2;
   localparam int SEL_WD0   = 3;
   localparam int SEL_ERR   = 4;

   typedef struct {
      string       nm;
      int          sel;
      logic [31:0] exp;
   } probe_t;

   typedef struct {
      logic        err;
      logic [31:0] w0;
      logic [31:0] w1;
   } done_t;

   logic clk = 1'b0;
   logic reset_n;

   n64_cfg_bridge_if bus ();

   n64_cfg_bridge #(
      .TIMEOUT_CYCLES(32'd16)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   probe_t probe_q[$];
   done_t  done_q[$];
   int     irq_exp = 0;

   logic        m_busy;
   logic        m_err;
   logic        m_tflag;
   logic [7:0]  m_cmd;
   logic [31:0] m_a0;
   logic [31:0] m_a1;
   logic [31:0] m_res0;
   logic [31:0] m_res1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: compare whatever the DUT presents this cycle
   always @(negedge clk) begin
      if (bus.cfg_done === 1'b1) begin
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cfg_done: got 1 expected 0");
         end else begin
            done_t d;
            d = done_q.pop_front();
            chk("done_error", {31'd0, bus.cfg_error}, {31'd0, d.err});
            chk("done_wdata_0", bus.cfg_wdata_0, d.w0);
            chk("done_wdata_1", bus.cfg_wdata_1, d.w1);
         end
      end
      if (bus.cfg_irq === 1'b1) begin
         checks++;
         if (irq_exp == 0) begin
            errors++;
            $display("FAIL unexpected_cfg_irq: got 1 expected 0");
         end else begin
            irq_exp--;
         end
      end
      while (probe_q.size() > 0) begin
         probe_t p;
         logic [31:0] act;
         p = probe_q.pop_front();
         case (p.sel)
            SEL_RDATA: act = bus.cpu_rdata;
            SEL_CIRQ:  act = {31'd0, bus.cpu_irq};
            SEL_DONE:  act = {31'd0, bus.cfg_done};
            SEL_WD0:   act = bus.cfg_wdata_0;
            default:   act = {31'd0, bus.cfg_error};
         endcase
         chk(p.nm, act, p.exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string nm, input int sel,
                        input logic [31:0] exp);
      probe_t p;
      p.nm  = nm;
      p.sel = sel;
      p.exp = exp;
      probe_q.push_back(p);
   endtask

   function automatic logic [31:0] m_status();
      return {29'd0, m_tflag, m_err, m_busy};
   endfunction

   task automatic m_reset();
      m_busy  = 1'b0;
      m_err   = 1'b0;
      m_tflag = 1'b0;
      m_cmd   = '0;
      m_a0    = '0;
      m_a1    = '0;
      m_res0  = '0;
      m_res1  = '0;
   endtask

   task automatic cpu_rd(input string nm, input logic [2:0] a,
                         input logic [31:0] exp);
      bus.cpu_address = a;
      probe(nm, SEL_RDATA, exp);
      tick();
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
      done_t e;
      if (a == REG_RESULT0) m_res0 = d;
      if (a == REG_RESULT1) m_res1 = d;
      if (a == REG_CTRL) begin
         if (d[CTRL_N64_IRQ]) irq_exp++;
         if (d[CTRL_DONE] && m_busy) begin
            m_busy  = 1'b0;
            m_err   = d[CTRL_ERROR];
            m_tflag = 1'b0;
            e.err   = m_err;
            e.w0    = m_res0;
            e.w1    = m_res1;
            done_q.push_back(e);
         end
      end
      bus.cpu_address = a;
      bus.cpu_wdata   = d;
      bus.cpu_write   = 1'b1;
      tick();
      bus.cpu_write = 1'b0;
   endtask

   task automatic post(input logic [7:0] c, input logic [31:0] a0,
                       input logic [31:0] a1);
      bus.cfg_pending = 1'b1;
      bus.cfg_cmd     = c;
      bus.cfg_rdata_0 = a0;
      bus.cfg_rdata_1 = a1;
      tick();
      m_busy  = 1'b1;
      m_err   = 1'b0;
      m_tflag = 1'b0;
      m_cmd   = c;
      m_a0    = a0;
      m_a1    = a1;
   endtask

   task automatic check_latched();
      probe("cpu_irq_busy", SEL_CIRQ, 32'd1);
      cpu_rd("rd_cmd", REG_CMD, {24'd0, m_cmd});
      cpu_rd("rd_arg0", REG_ARG0, m_a0);
      cpu_rd("rd_arg1", REG_ARG1, m_a1);
      cpu_rd("rd_status_busy", REG_CTRL, m_status());
   endtask

   // after the completing write: DONE cycle, then into IDLE
   task automatic after_done(input logic b2b, input logic [7:0] c,
                             input logic [31:0] a0,
                             input logic [31:0] a1);
      probe("cpu_irq_done", SEL_CIRQ, 32'd0);
      probe("cfg_done_high", SEL_DONE, 32'd1);
      bus.cfg_pending = b2b;
      bus.cfg_cmd     = c;
      bus.cfg_rdata_0 = a0;
      bus.cfg_rdata_1 = a1;
      cpu_rd("rd_status_done", REG_CTRL, m_status());
      probe("cfg_done_low", SEL_DONE, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  c;
      logic [31:0] a0;
      logic [31:0] a1;
      logic        b2b;
      logic [31:0] ctrl;
      m_reset();
      reset_n         = 1'b0;
      bus.cfg_pending = 1'b0;
      bus.cfg_cmd     = '0;
      bus.cfg_rdata_0 = '0;
      bus.cfg_rdata_1 = '0;
      bus.cpu_address = '0;
      bus.cpu_write   = 1'b0;
      bus.cpu_wdata   = '0;
      tick();
      probe("rst_cpu_irq", SEL_CIRQ, 32'd0);
      probe("rst_cfg_done", SEL_DONE, 32'd0);
      probe("rst_cfg_error", SEL_ERR, 32'd0);
      cpu_rd("rst_status", REG_CTRL, 32'd0);
      reset_n = 1'b1;
      tick();

      // basic command
      post(8'h42, 32'h1234_5678, 32'hDEAD_BEEF);
      check_latched();
      cpu_wr(REG_RESULT0, 32'hCAFE_0001);
      probe("wdata0_written", SEL_WD0, 32'hCAFE_0001);
      cpu_wr(REG_CTRL, 32'h1);
      after_done(1'b0, 8'h0, 32'h0, 32'h0);

      // error completion, then cleared by next accept
      post(8'h07, 32'h1, 32'h2);
      cpu_wr(REG_CTRL, 32'h3);
      after_done(1'b0, 8'h0, 32'h0, 32'h0);
      probe("err_sticky_idle", SEL_ERR, 32'd1);
      tick();
      post(8'h08, 32'h3, 32'h4);
      probe("err_cleared", SEL_ERR, 32'd0);
      check_latched();
      cpu_wr(REG_CTRL, 32'h1);

      // back-to-back: new command posted while in DONE
      after_done(1'b1, 8'hA5, 32'h0BAD_F00D, 32'h600D_CAFE);
      post(8'hA5, 32'h0BAD_F00D, 32'h600D_CAFE);
      check_latched();
      cpu_wr(REG_CTRL, 32'h5);
      after_done(1'b0, 8'h0, 32'h0, 32'h0);

      // stray CTRL writes and unused indices in IDLE
      cpu_wr(REG_CTRL, 32'h4);
      cpu_wr(REG_CTRL, 32'h1);
      cpu_wr(REG_CTRL, 32'h3);
      cpu_wr(3'd6, 32'hFFFF_FFFF);
      cpu_rd("rd_idx6", 3'd6, 32'd0);
      cpu_rd("rd_idx7", 3'd7, 32'd0);
      cpu_rd("rd_status_idle", REG_CTRL, m_status());
      cpu_wr(REG_RESULT1, 32'h1111_2222);
      cpu_rd("rd_result1", REG_RESULT1, m_res1);

      // randomized transactions
      b2b = 1'b0;
      c   = 8'($urandom);
      a0  = $urandom;
      a1  = $urandom;
      for (int n = 0; n < 40; n++) begin
         post(c, a0, a1);
         check_latched();
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 1) == 1) cpu_wr(REG_RESULT0, $urandom);
         if ($urandom_range(0, 1) == 1) cpu_wr(REG_RESULT1, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            cpu_wr(REG_CTRL, {29'd0, 1'b1, 1'($urandom), 1'b0});
         end
         ctrl = {29'd0, 2'($urandom), 1'b1};
         cpu_wr(REG_CTRL, ctrl);
         b2b = 1'($urandom);
         c   = 8'($urandom);
         a0  = $urandom;
         a1  = $urandom;
         after_done(b2b, c, a0, a1);
         cpu_rd("rd_result0", REG_RESULT0, m_res0);
      end
      bus.cfg_pending = 1'b0;
      tick();

      // reset while busy
      post(8'h33, 32'h5, 32'h6);
      cpu_wr(REG_RESULT0, 32'h5555_AAAA);
      reset_n         = 1'b0;
      bus.cfg_pending = 1'b0;
      m_reset();
      #1;
      probe("rst_mid_cpu_irq", SEL_CIRQ, 32'd0);
      probe("rst_mid_done", SEL_DONE, 32'd0);
      probe("rst_mid_wdata0", SEL_WD0, 32'd0);
      cpu_rd("rst_mid_status", REG_CTRL, 32'd0);
      cpu_rd("rst_mid_cmd", REG_CMD, 32'd0);
      reset_n = 1'b1;
      tick();
      cpu_rd("post_rst_status", REG_CTRL, 32'd0);

`ifdef CFG_BRIDGE_TIMEOUT_EN
      begin
         done_t e;
         post(8'h99, 32'h9, 32'hA);
         repeat (15) tick();
         probe("to_irq_cycle16", SEL_CIRQ, 32'd1);
         m_busy  = 1'b0;
         m_err   = 1'b1;
         m_tflag = 1'b1;
         e.err   = 1'b1;
         e.w0    = m_res0;
         e.w1    = m_res1;
         done_q.push_back(e);
         tick();
         after_done(1'b0, 8'h0, 32'h0, 32'h0);
         post(8'h9A, 32'hB, 32'hC);
         repeat (15) tick();
         cpu_wr(REG_CTRL, 32'h1);
         after_done(1'b0, 8'h0, 32'h0, 32'h0);
      end
`endif

      repeat (3) tick();
      chk("done_queue_drained", done_q.size(), 32'd0);
      chk("irq_queue_drained", irq_exp, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
